mux_scan_n: RTL and testbench

Parametrised N-input, WIDTH-bit registered multiplexer with two select modes. In manual mode an external select chooses the channel. In auto mode an internal dwell counter steps round-robin through the channels and skips any channel that is masked. It is the general successor to the fixed 4-way selector and is used for time-multiplexed display and bus sharing, for example scanning digit data onto a shared 7-segment bus.

---
 rtl/mux_scan_n.sv | 103 ++++++++++
 tb/tb_mux_scan_n.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// N-input registered multiplexer with manual select and a masked round-robin auto scan.
// Output data and select index update together, one cycle after d/sel_in/mode.
module mux_scan_n #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] d,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               en,
  input  logic [N-1:0]       skip_mask,
  output logic [WIDTH-1:0]   y,
  output logic [SEL_W-1:0]   sel_out,
  output logic [N-1:0]       onehot,
  output logic               wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] ch [N];
  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = d[k*WIDTH +: WIDTH];
  end

  // Circular search split in two: lowest unmasked index above sel_q, else lowest at/below it.
  logic             hi_found, lo_found;
  logic [SEL_W-1:0] hi_idx, lo_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (!skip_mask[k]) begin
        if (SEL_W'(k) > sel_q) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(k);
        end else begin
          lo_found = 1'b1;
          lo_idx   = SEL_W'(k);
        end
      end
    end
  end

  logic all_masked;
  assign all_masked = &skip_mask;

  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    y_d    = '0;
    if (en) begin
      if (!mode) begin
        if (32'(sel_in) < N) sel_d = sel_in;
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (hi_found) begin
          sel_d = hi_idx;
        end else if (lo_found) begin
          sel_d  = lo_idx;
          wrap_d = (lo_idx < sel_q);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (!(en && mode && all_masked)) y_d = ch[sel_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign y       = y_q;
  assign sel_out = sel_q;
  assign onehot  = N'(1) << sel_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: an N=4 and an N=3 instance share one stimulus stream and are
// checked every cycle against a behavioural model, plus a few literal expectations.
module tb_mux_scan_n;
  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d;
  logic        mode, en;
  logic [1:0]  sel_in;
  logic [3:0]  mask;

  logic [3:0] y_a, y_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] oh_a;
  logic [2:0] oh_b;
  logic       wrap_a, wrap_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.WIDTH(4), .N(4), .DWELL(DWELL)) u_a (
    .clk(clk), .rst(rst), .d(d), .mode(mode), .sel_in(sel_in), .en(en),
    .skip_mask(mask), .y(y_a), .sel_out(sel_a), .onehot(oh_a), .wrap(wrap_a)
  );

  mux_scan_n #(.WIDTH(4), .N(3), .DWELL(DWELL)) u_b (
    .clk(clk), .rst(rst), .d(d[11:0]), .mode(mode), .sel_in(sel_in), .en(en),
    .skip_mask(mask[2:0]), .y(y_b), .sel_out(sel_b), .onehot(oh_b), .wrap(wrap_b)
  );

  // Behavioural model: index 0 models the N=4 instance, index 1 the N=3 instance.
  int       nn [2] = '{4, 3};
  int       msel [2];
  int       mcnt [2];
  int       my [2];
  int       mwrap [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic mstep(input int u);
    int n    = nn[u];
    int nsel = msel[u];
    int cand;
    bit allm = 1'b1;
    mwrap[u] = 0;
    for (int k = 0; k < n; k++) if (!mask[k]) allm = 1'b0;
    if (en) begin
      if (!mode) begin
        if (int'(sel_in) < n) nsel = int'(sel_in);
        mcnt[u] = 0;
      end else if (mcnt[u] < DWELL - 1) begin
        mcnt[u]++;
      end else begin
        mcnt[u] = 0;
        for (int s = 1; s <= n; s++) begin
          cand = (msel[u] + s) % n;
          if (!mask[cand]) begin
            nsel = cand;
            break;
          end
        end
        mwrap[u] = (nsel < msel[u]) ? 1 : 0;
      end
    end
    my[u]   = (en && mode && allm) ? 0 : int'(d[nsel*4 +: 4]);
    msel[u] = nsel;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        msel[u] = 0; mcnt[u] = 0; my[u] = 0; mwrap[u] = 0;
      end
    end else begin
      mstep(0);
      mstep(1);
    end
  end

  always @(negedge clk) begin
    chk("a_y",      32'(y_a),    32'(my[0]));
    chk("a_sel",    32'(sel_a),  32'(msel[0]));
    chk("a_onehot", 32'(oh_a),   32'(1) << msel[0]);
    chk("a_wrap",   32'(wrap_a), 32'(mwrap[0]));
    chk("b_y",      32'(y_b),    32'(my[1]));
    chk("b_sel",    32'(sel_b),  32'(msel[1]));
    chk("b_onehot", 32'(oh_b),   32'(1) << msel[1]);
    chk("b_wrap",   32'(wrap_b), 32'(mwrap[1]));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; en = 1'b1; sel_in = 2'd0; mask = 4'h0; d = 16'hDCBA;
    tick(2);
    chk("lit_reset_y",      32'(y_a), 32'h0);
    chk("lit_reset_onehot", 32'(oh_a), 32'h1);
    rst = 1'b0;
    tick();
    chk("lit_first_y", 32'(y_a), 32'hA);
    sel_in = 2'd2;
    tick();
    chk("lit_man_y",      32'(y_a),   32'hC);
    chk("lit_man_sel",    32'(sel_a), 32'd2);
    chk("lit_man_onehot", 32'(oh_a),  32'b0100);

    // Auto scan from channel 0
    sel_in = 2'd0;
    tick();
    mode = 1'b1;
    tick(3);
    chk("lit_auto_hold0", 32'(sel_a), 32'd0);
    tick();
    chk("lit_auto_step1", 32'(sel_a), 32'd1);
    tick(12);
    chk("lit_auto_wrap_sel", 32'(sel_a),  32'd0);
    chk("lit_auto_wrap",     32'(wrap_a), 32'd1);
    tick();
    chk("lit_auto_wrap_end", 32'(wrap_a), 32'd0);

    mask = 4'b0110;
    tick(16);

    mask = 4'hF;
    tick(6);
    chk("lit_allmask_y",    32'(y_a),    32'h0);
    chk("lit_allmask_wrap", 32'(wrap_a), 32'h0);

    mode = 1'b0; sel_in = 2'd0;
    tick();
    mode = 1'b1; mask = 4'b1110;
    tick(10);
    chk("lit_single_sel", 32'(sel_a), 32'd0);

    // Freeze at sel=1, cnt=2
    mask = 4'h0; mode = 1'b0; sel_in = 2'd0;
    tick();
    mode = 1'b1;
    tick(6);
    chk("lit_pre_freeze", 32'(sel_a), 32'd1);
    en = 1'b0;
    d[7:4] = 4'h5;
    tick(10);
    chk("lit_freeze_sel", 32'(sel_a), 32'd1);
    chk("lit_freeze_y",   32'(y_a),   32'h5);
    en = 1'b1;
    tick();
    chk("lit_unfreeze_hold", 32'(sel_a), 32'd1);
    tick();
    chk("lit_unfreeze_step", 32'(sel_a), 32'd2);

    // Asynchronous reset mid-dwell, checked well before the next rising edge
    tick();
    #2 rst = 1'b1;
    #1;
    chk("lit_async_y",      32'(y_a),   32'h0);
    chk("lit_async_sel",    32'(sel_a), 32'h0);
    chk("lit_async_onehot", 32'(oh_a),  32'h1);
    chk("lit_async_b_sel",  32'(sel_b), 32'h0);
    tick();
    rst = 1'b0;

    // Out-of-range manual select on the N=3 instance
    mode = 1'b0; sel_in = 2'd2;
    tick();
    sel_in = 2'd3;
    tick();
    chk("lit_n3_ignore", 32'(sel_b), 32'd2);
    mode = 1'b1;
    tick(15);

    for (int i = 0; i < 400; i++) begin
      mode   = ($urandom_range(0, 4) != 0);
      en     = ($urandom_range(0, 9) != 0);
      sel_in = 2'($urandom);
      mask   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      d      = 16'($urandom);
      tick($urandom_range(1, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
